// File: rtl/celement_merge_arb_if.sv
// Bundle for the clocked round-robin C-element merge: N_CH four-phase
// request/acknowledge inputs, one merged request/acknowledge output, plus status.
interface celement_merge_arb_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
);
    localparam int IDW = $clog2(N_CH);

    // Four-phase handshake on each side: the requester raises send, the
    // responder raises ack, the requester drops send, the responder drops ack.
    // No new request may start on a channel until its ack has returned low.
    logic              lopen;
    logic [N_CH-1:0]   sendin;
    logic [N_CH-1:0]   ackout;
    logic              sendout;
    logic              ackin;
    logic [IDW-1:0]    grant_id;
    logic [N_CH-1:0]   cp;
    logic              aeb;
    logic [CNT_W-1:0]  cont_cnt;
    logic              proto_err;
    logic [1:0]        state_dbg;
    logic [IDW-1:0]    ptr_dbg;

    modport master (
        input  lopen, sendin, ackin,
        output ackout, sendout, grant_id, cp, aeb, cont_cnt, proto_err,
               state_dbg, ptr_dbg
    );

    modport slave (
        output lopen, sendin, ackin,
        input  ackout, sendout, grant_id, cp, aeb, cont_cnt, proto_err,
               state_dbg, ptr_dbg
    );
endinterface

// File: rtl/celement_merge_arb.sv
// Round-robin merge of N_CH four-phase channels onto one downstream handshake,
// with grant strobe, contention strobe/counter and a sticky protocol-error flag.
module celement_merge_arb #(
    parameter int N_CH  = 4,
    parameter int IDW   = $clog2(N_CH),
    parameter int CNT_W = 8
) (
    input logic                 clk,
    input logic                 reset,
    celement_merge_arb_if.master bus
);
    localparam int SW = IDW + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    state_t            state_q, state_n;
    logic [IDW-1:0]    ptr_q, ptr_n;
    logic              sendout_q, sendout_n;
    logic [N_CH-1:0]   ackout_q, ackout_n;
    logic [IDW-1:0]    grant_q, grant_n;
    logic [N_CH-1:0]   cp_q, cp_n;
    logic              aeb_q, aeb_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic              perr_q, perr_n;
    logic              ack_low_q, ack_low_n;

    logic [N_CH-1:0]   req;
    logic [IDW-1:0]    pick;
    logic              found;
    logic [SW-1:0]     s;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            sendout_q <= 1'b0;
            ackout_q  <= '0;
            grant_q   <= '0;
            cp_q      <= '0;
            aeb_q     <= 1'b0;
            cnt_q     <= '0;
            perr_q    <= 1'b0;
            ack_low_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            ptr_q     <= ptr_n;
            sendout_q <= sendout_n;
            ackout_q  <= ackout_n;
            grant_q   <= grant_n;
            cp_q      <= cp_n;
            aeb_q     <= aeb_n;
            cnt_q     <= cnt_n;
            perr_q    <= perr_n;
            ack_low_q <= ack_low_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        ptr_n     = ptr_q;
        sendout_n = sendout_q;
        ackout_n  = ackout_q;
        grant_n   = grant_q;
        cp_n      = '0;
        aeb_n     = 1'b0;
        cnt_n     = cnt_q;
        perr_n    = perr_q;
        ack_low_n = ack_low_q;
        req       = bus.sendin & ~ackout_q;
        pick      = '0;
        found     = 1'b0;
        s         = '0;

        // First eligible channel at or above ptr, wrapping past N_CH-1.
        for (int i = 0; i < N_CH; i++) begin
            s = {1'b0, ptr_q} + SW'(i);
            if (s >= SW'(N_CH)) s = s - SW'(N_CH);
            if (!found && req[s[IDW-1:0]]) begin
                pick  = s[IDW-1:0];
                found = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.lopen && found) begin
                    sendout_n  = 1'b1;
                    grant_n    = pick;
                    cp_n[pick] = 1'b1;
                    state_n    = WAIT_ACK;
                    // Two or more bits set means req & (req-1) is non-zero.
                    if (|(req & (req - N_CH'(1)))) begin
                        aeb_n = 1'b1;
                        if (!(&cnt_q)) cnt_n = cnt_q + CNT_W'(1);
                    end
                end
            end
            WAIT_ACK: begin
                if (!bus.sendin[grant_q]) perr_n = 1'b1;
                if (bus.ackin) begin
                    ackout_n[grant_q] = 1'b1;
                    sendout_n         = 1'b0;
                    ack_low_n         = 1'b0;
                    state_n           = WAIT_REL;
                end
            end
            WAIT_REL: begin
                // Downstream ack may fall only once; a second rise is an error.
                if (!bus.ackin) ack_low_n = 1'b1;
                else if (ack_low_q) perr_n = 1'b1;
                if (!bus.sendin[grant_q] && !bus.ackin) begin
                    ackout_n = '0;
                    ptr_n    = (grant_q == IDW'(N_CH - 1)) ? '0 : grant_q + IDW'(1);
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.sendout   = sendout_q;
    assign bus.ackout    = ackout_q;
    assign bus.grant_id  = grant_q;
    assign bus.cp        = cp_q;
    assign bus.aeb       = aeb_q;
    assign bus.cont_cnt  = cnt_q;
    assign bus.proto_err = perr_q;
    assign bus.state_dbg = state_q;
    assign bus.ptr_dbg   = ptr_q;
endmodule
